// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC, one-outstanding imem handshake, redirects.
// Optional FETCH_ADEL_EN: misaligned PCs raise if_adel instead of fetching.
module fetch_ctrl #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'hbfc00000,
  parameter logic [WIDTH-1:0] EXC_VEC = 32'hbfc00380
) (
  input  logic             clk,
  input  logic             rst,
  output logic             inst_req,
  output logic [WIDTH-1:0] inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [WIDTH-1:0] inst_rdata,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             exc,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_inst,
`ifdef FETCH_ADEL_EN
  output logic             if_adel,
`endif
  output logic [WIDTH-1:0] pc
);

  typedef enum logic [1:0] {BOOT, REQ, WAIT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] pc_n, req_pc, req_pc_n, tgt;
  logic [WIDTH-1:0] ifpc_n, ifinst_n;
  logic             discard, discard_n, ifv_n;
  logic             redir, full, hs;
`ifdef FETCH_ADEL_EN
  logic             adel_n, misal;
`endif

  assign inst_addr = pc;

  always_comb begin
    redir = exc | eret | br_taken;
    priority case (1'b1)
      exc:     tgt = EXC_VEC;
      eret:    tgt = epc;
      default: tgt = br_target;
    endcase
    full = if_valid && stall;
`ifdef FETCH_ADEL_EN
    misal = pc[1:0] != 2'b00;
    inst_req = (state == REQ) && !full && !misal;
`else
    inst_req = (state == REQ) && !full;
`endif
    hs = inst_req && inst_addr_ok;
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    req_pc_n  = req_pc;
    discard_n = discard;
    ifv_n     = if_valid && stall;
    ifpc_n    = if_pc;
    ifinst_n  = if_inst;
`ifdef FETCH_ADEL_EN
    adel_n    = if_adel;
`endif
    unique case (state)
      BOOT: state_n = REQ;
      REQ: begin
        if (hs) begin
          req_pc_n = pc;
          pc_n     = pc + WIDTH'(4);
          state_n  = WAIT;
        end
`ifdef FETCH_ADEL_EN
        else if (misal && !full) begin
          ifv_n    = 1'b1;
          ifpc_n   = pc;
          ifinst_n = '0;
          adel_n   = 1'b1;
        end
`endif
      end
      WAIT: begin
        if (inst_data_ok) begin
          state_n   = REQ;
          discard_n = 1'b0;
          if (!discard) begin
            ifv_n    = 1'b1;
            ifpc_n   = req_pc;
            ifinst_n = inst_rdata;
`ifdef FETCH_ADEL_EN
            adel_n   = 1'b0;
`endif
          end
        end
      end
      default: state_n = BOOT;
    endcase
    // A redirect kills the output and any fetch still owed to us
    if (redir) begin
      pc_n  = tgt;
      ifv_n = 1'b0;
      if ((state == WAIT && !inst_data_ok) || hs) begin
        discard_n = 1'b1;
        state_n   = WAIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      req_pc   <= '0;
      discard  <= 1'b0;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= '0;
`ifdef FETCH_ADEL_EN
      if_adel  <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      req_pc   <= req_pc_n;
      discard  <= discard_n;
      if_valid <= ifv_n;
      if_pc    <= ifpc_n;
      if_inst  <= ifinst_n;
`ifdef FETCH_ADEL_EN
      if_adel  <= adel_n;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios then random traffic vs a
// transaction-level fetch model and a latency-randomised memory.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'hbfc00000;
  localparam logic [31:0] EXC_PC = 32'hbfc00380;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        exc = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] epc = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [31:0] pc;
`ifdef FETCH_ADEL_EN
  logic        if_adel;
`endif

  fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .exc(exc), .eret(eret), .epc(epc),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
`ifdef FETCH_ADEL_EN
    .if_adel(if_adel),
`endif
    .pc(pc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model: next fetch address, one outstanding fetch, output entry
  logic        m_boot, m_busy, m_cancel, m_ov, m_adel;
  logic [31:0] m_pc, m_fpc, m_opc, m_oinst;

  // memory: accepts requests, answers after a latency, data = addr ^ 1
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt = 0;
  int          lat_force = 0;
  logic [31:0] seen[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot = 1'b1; m_busy = 1'b0; m_cancel = 1'b0;
    m_ov = 1'b0; m_adel = 1'b0; m_pc = RST_PC;
    m_fpc = '0; m_opc = '0; m_oinst = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exc = 1'b0; eret = 1'b0; br_taken = 1'b0;
    inst_data_ok = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mem_busy = 1'b0;
    model_reset();
  endtask

  // one clock: compare at negedge+1, then advance model and memory
  task automatic step();
    logic        er, free, redir, hs, arrive;
    logic [31:0] tgt;
    inst_data_ok = mem_busy && mem_cnt == 0;
    inst_rdata = mem_addr ^ 32'h1;
    #1;
    free = !(m_ov && stall);
    er = !m_boot && !m_busy && free;
`ifdef FETCH_ADEL_EN
    if (m_pc[1:0] != 2'b00) er = 1'b0;
`endif
    chk("inst_req", 32'(inst_req), 32'(er));
    if (er) chk("inst_addr", inst_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("if_valid", 32'(if_valid), 32'(m_ov));
    if (m_ov) begin
      chk("if_pc", if_pc, m_opc);
      chk("if_inst", if_inst, m_oinst);
`ifdef FETCH_ADEL_EN
      chk("if_adel", 32'(if_adel), 32'(m_adel));
`endif
    end
    if (inst_req && inst_addr_ok) seen.push_back(inst_addr);

    redir = exc | eret | br_taken;
    tgt = exc ? EXC_PC : (eret ? epc : br_target);
    hs = er && inst_addr_ok;
    arrive = m_busy && inst_data_ok;
    if (m_ov && !stall) m_ov = 1'b0;
    if (arrive && !m_cancel) begin
      m_ov = 1'b1; m_opc = m_fpc; m_oinst = m_fpc ^ 32'h1; m_adel = 1'b0;
    end
`ifdef FETCH_ADEL_EN
    if (!m_boot && !m_busy && m_pc[1:0] != 2'b00 && free) begin
      m_ov = 1'b1; m_opc = m_pc; m_oinst = '0; m_adel = 1'b1;
    end
`endif
    if (redir) m_ov = 1'b0;
    if (arrive) begin m_busy = 1'b0; m_cancel = 1'b0; end
    if (hs) begin
      m_busy = 1'b1; m_fpc = m_pc; m_cancel = redir; m_pc = m_pc + 32'd4;
    end else if (redir && m_busy) m_cancel = 1'b1;
    if (redir) m_pc = tgt;
    m_boot = 1'b0;

    if (inst_data_ok) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (inst_req && inst_addr_ok) begin
      mem_busy = 1'b1;
      mem_addr = inst_addr;
      mem_cnt = lat_force >= 0 ? lat_force : int'($urandom_range(0, 2));
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20 && m_busy; i++) step();
    chk(tag, 32'(m_busy), 32'd0);
  endtask

  task automatic wait_busy(input string tag);
    for (int i = 0; i < 20 && !m_busy; i++) step();
    chk(tag, 32'(m_busy), 32'd1);
  endtask

  task automatic last_req(input string tag, input logic [31:0] exp);
    chk({tag, "_any"}, 32'(seen.size() > 0), 32'd1);
    if (seen.size() > 0) chk(tag, seen[$], exp);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_inst_req", 32'(inst_req), 32'd0);

    // sequential fetch, single-cycle memory
    inst_addr_ok = 1'b1;
    lat_force = 0;
    repeat (5) step();
    chk("seq_count", seen.size(), 32'd2);
    if (seen.size() >= 2) begin
      chk("seq0", seen[0], 32'hbfc00000);
      chk("seq1", seen[1], 32'hbfc00004);
    end

    // decode stall with a full output entry
    stall = 1'b1;
    repeat (5) begin
      step();
      #1;
      chk("stall_if_pc", if_pc, 32'hbfc00004);
      chk("stall_if_inst", if_inst, 32'hbfc00005);
      chk("stall_req", 32'(inst_req), 32'd0);
    end
    stall = 1'b0;
    step();
    last_req("stall_release", 32'hbfc00008);

    // branch while a slow fetch is in flight
    lat_force = 3;
    wait_busy("br_wait_busy");
    br_taken = 1'b1; br_target = 32'h80001000;
    step();
    br_taken = 1'b0;
    for (int i = 0; i < 12 && seen[$] != 32'h80001000; i++) step();
    last_req("br_redirect", 32'h80001000);

    // redirect priority, issued from REQ without a handshake
    lat_force = 0;
    inst_addr_ok = 1'b0;
    wait_idle("pri_idle0");
    exc = 1'b1; eret = 1'b1; br_taken = 1'b1;
    epc = 32'h80000100; br_target = 32'h80002000;
    step();
    exc = 1'b0; eret = 1'b0; br_taken = 1'b0;
    inst_addr_ok = 1'b1;
    step();
    last_req("pri_exc", EXC_PC);
    inst_addr_ok = 1'b0;
    wait_idle("pri_idle1");
    eret = 1'b1; br_taken = 1'b1;
    step();
    eret = 1'b0; br_taken = 1'b0;
    inst_addr_ok = 1'b1;
    step();
    last_req("pri_eret", 32'h80000100);

    // reset while waiting for data
    lat_force = 3;
    wait_busy("rst_wait_busy");
    do_reset();
    chk("rst2_if_valid", 32'(if_valid), 32'd0);
    chk("rst2_if_pc", if_pc, 32'd0);
    chk("rst2_if_inst", if_inst, 32'd0);
    chk("rst2_inst_req", 32'(inst_req), 32'd0);
    seen.delete();
    step();
    chk("rst2_boot_quiet", seen.size(), 32'd0);
    step();
    last_req("rst2_first", RST_PC);

`ifdef FETCH_ADEL_EN
    lat_force = 0;
    inst_addr_ok = 1'b0;
    wait_idle("adel_idle");
    br_taken = 1'b1; br_target = 32'h80000002;
    step();
    br_taken = 1'b0;
    inst_addr_ok = 1'b1;
    repeat (2) step();
    #1;
    chk("adel_req", 32'(inst_req), 32'd0);
    chk("adel_valid", 32'(if_valid), 32'd1);
    chk("adel_pc", if_pc, 32'h80000002);
    chk("adel_flag", 32'(if_adel), 32'd1);
    exc = 1'b1;
    step();
    exc = 1'b0;
    step();
    last_req("adel_exc", EXC_PC);
`endif

    // random traffic
    lat_force = -1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      stall = $urandom_range(0, 9) < 3;
      inst_addr_ok = $urandom_range(0, 9) < 7;
      exc = $urandom_range(0, 49) == 0;
      eret = $urandom_range(0, 29) == 0;
      br_taken = $urandom_range(0, 11) == 0;
      epc = $urandom & 32'hfffffffc;
      br_target = $urandom & 32'hfffffffc;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
